// File: rtl/ifetch_t_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_t_pkg
// Description : Shared constants for the instruction fetch stage: fetch FSM
//               state encodings and the instruction word size in bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_t_pkg;

    // Fetch FSM state encodings
    localparam int              c_STATE_W  = 2;
    localparam logic [c_STATE_W-1:0] c_IF_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_IF_REQ  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_IF_WAIT = 2'd2;

    // Every instruction is one 32-bit word
    localparam int c_INST_BYTES = 4;

endpackage : ifetch_t_pkg
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_fifo
// Description : Synchronous DEPTH-entry FIFO of {pc, instruction}. Flush has
//               priority over push and pop; push and pop may coincide at any
//               occupancy. The head is read combinationally from storage.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import ifetch_t_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_pc,
    input  logic [WIDTH-1:0]         push_inst,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_pc,
    output logic [WIDTH-1:0]         head_inst
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_pc_mem   [DEPTH];
    logic [WIDTH-1:0]   r_inst_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // A pop frees the slot a same-cycle push may need when the FIFO is full
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_pc   = r_pc_mem[r_rd_ptr];
    assign head_inst = r_inst_mem[r_rd_ptr];

    // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_inst_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_pc_mem[r_wr_ptr]   <= push_pc;
                r_inst_mem[r_wr_ptr] <= push_inst;
                r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : ifetch_fifo
`default_nettype wire

// File: rtl/ifetch_t.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_t
// Description : Instruction fetch stage. Holds the PC, issues single-word
//               read requests (one outstanding at most), queues returned
//               words with their PCs and hands them to decode via
//               valid/ready. A redirect flushes queued and in-flight fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_t
    import ifetch_t_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [WIDTH-1:0]     redirect_pc,
    output logic                 mem_req_valid,
    output logic [WIDTH-1:0]     mem_req_addr,
    output logic [WIDTH-1:0]     mem_req_data,
    output logic [WIDTH/8-1:0]   mem_req_mask,
    input  logic                 mem_resp_valid,
    input  logic [WIDTH-1:0]     mem_resp_data,
    output logic                 inst_valid,
    output logic [WIDTH-1:0]     inst_data,
    output logic [WIDTH-1:0]     inst_pc,
    input  logic                 inst_ready
);

    localparam int               c_CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0] c_PC_STEP    = WIDTH'(c_INST_BYTES);
    localparam logic [WIDTH-1:0] c_ALIGN_MASK = ~(WIDTH'(c_INST_BYTES - 1));

    logic [c_STATE_W-1:0] r_state;
    logic [WIDTH-1:0]     r_pc;
    logic                 r_drop;
    logic                 r_req_valid;
    logic [WIDTH-1:0]     r_req_addr;

    logic [WIDTH-1:0]     w_redirect_pc;
    logic                 w_has_room;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_CNT_W-1:0]   w_fifo_count;

    assign w_redirect_pc = redirect_pc & c_ALIGN_MASK;

    // Only issued from IDLE, so no fetch is outstanding: the live count is
    // the whole occupancy and a later push can never overflow.
    assign w_has_room = (w_fifo_count < c_CNT_W'(DEPTH));

    // Capture only a wanted word; a redirect in the arrival cycle kills it
    assign w_push = (r_state == c_IF_WAIT) & mem_resp_valid & ~r_drop
                  & ~redirect_valid & ~w_fifo_full;
    assign w_pop  = ~w_fifo_empty & inst_ready;

    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_data  = '0;
    assign mem_req_mask  = '0;
    assign inst_valid    = ~w_fifo_empty;

    // Fetch FSM: PC, drop flag and registered request strobe/address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IF_IDLE;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= RESET_PC;
        end else begin
            case (r_state)
                c_IF_IDLE: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirect_pc;
                    end else if (mem_resp_valid && w_has_room) begin
                        r_state     <= c_IF_REQ;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= r_pc;
                    end
                end
                c_IF_REQ: begin
                    // Address stays put: memory samples it while busy
                    r_req_valid <= 1'b0;
                    r_state     <= c_IF_WAIT;
                    if (redirect_valid) begin
                        r_pc   <= w_redirect_pc;
                        r_drop <= 1'b1;
                    end
                end
                c_IF_WAIT: begin
                    if (mem_resp_valid) begin
                        r_state <= c_IF_IDLE;
                        r_drop  <= 1'b0;
                        if (redirect_valid) begin
                            r_pc <= w_redirect_pc;
                        end else if (!r_drop) begin
                            r_pc <= r_pc + c_PC_STEP;
                        end
                    end else if (redirect_valid) begin
                        r_pc   <= w_redirect_pc;
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_IF_IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    ifetch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_pc   (r_pc),
        .push_inst (mem_resp_data),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count),
        .head_pc   (inst_pc),
        .head_inst (inst_data)
    );

endmodule : ifetch_t
`default_nettype wire

// File: tb/tb_ifetch_t.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_t
// Description : Self-checking bench for ifetch_t. A memory responder model
//               serves word reads; a monitor compares requests and delivered
//               instructions against a sequential-fetch reference model whose
//               expected stream lives in a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_t;

    localparam int          WIDTH    = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid = 1'b1;
    logic [31:0] mem_resp_data = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int req_count = 0;
    int pop_count = 0;
    bit rand_mem = 1'b0;

    ifetch_t #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial forever #5 clk = ~clk;

    // Memory contents: three known words at the bottom, a hash elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- memory responder ----------------
    int          m_busy = 0;
    logic [31:0] m_addr = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_valid) begin
                m_addr         = mem_req_addr;
                m_busy         = 2 + (rand_mem ? int'($urandom_range(0, 2)) : 0);
                mem_resp_valid = 1'b0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(m_addr);
                end
            end else begin
                mem_resp_valid = rand_mem ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] m_pc;
    logic [31:0] m_next_req;
    int          m_issued;
    int          m_popped;
    bit          prev_flush;
    bit          prev_hold;
    bit          prev_resp_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_data;
    int          gap;

    // Fetch proceeds sequentially from the restart PC, one word per step
    function automatic void top_up();
        while (exp_q.size() < DEPTH + 1) begin
            exp_q.push_back('{pc: m_pc, data: mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
        end
    endfunction

    function automatic void model_restart(input logic [31:0] pc);
        exp_q.delete();
        m_pc       = pc & ~32'h3;
        m_next_req = pc & ~32'h3;
        m_issued   = 0;
        m_popped   = 0;
        top_up();
    endfunction

    initial begin
        model_restart(RESET_PC);
        prev_flush      = 1'b1;
        prev_hold       = 1'b0;
        prev_resp_valid = 1'b1;
        gap             = 0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_req_valid) begin
                req_count++;
                check("req_addr", mem_req_addr, m_next_req);
                check("req_data_mask", {mem_req_data, mem_req_mask}, '0);
                check("req_mem_idle", prev_resp_valid, 1'b1);
                check("req_room", (m_issued - m_popped) < DEPTH, 1'b1);
                m_next_req = m_next_req + 32'd4;
                m_issued++;
            end
            if (prev_flush) check("valid_after_flush", inst_valid, 1'b0);
            if (prev_hold && inst_valid) check("head_stable", {inst_pc, inst_data}, {hold_pc, hold_data});
            if (inst_valid && inst_ready && !redirect_valid && !rst) begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst_data", inst_data, e.data);
                m_popped++;
                pop_count++;
                top_up();
            end
            prev_hold = inst_valid && !inst_ready && !redirect_valid && !rst;
            hold_pc   = inst_pc;
            hold_data = inst_data;
            if (rst || redirect_valid || inst_valid) gap = 0;
            else gap++;
            if (gap >= 60) begin
                check("fetch_progress_gap", gap, 0);
                gap = 0;
            end
            if (rst) model_restart(RESET_PC);
            else if (redirect_valid) model_restart(redirect_pc);
            prev_flush      = rst || redirect_valid;
            prev_resp_valid = mem_resp_valid;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] addr;
    bit          ok;
    int          n;
    int          start;

    task automatic wait_req(output logic [31:0] a, output bit found);
        found = 1'b0;
        a     = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (mem_req_valid) begin
                a     = mem_req_addr;
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout("wait_req");
    endtask

    initial begin
        // Reset values and first-fetch latency, then three in-order words
        rst        = 1'b1;
        inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        start = pop_count;
        rst   = 1'b0;
        #1;
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_req_addr", mem_req_addr, RESET_PC);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            #1;
            if (inst_valid) begin
                n = i;
                break;
            end
        end
        check("first_valid_latency", n, 4);
        for (int i = 0; i < 40 && (pop_count - start) < 3; i++) @(negedge clk);
        check("three_fetched", (pop_count - start) >= 3, 1'b1);

        // Decode stalled: FIFO fills to DEPTH and fetching stops
        @(negedge clk);
        rst        = 1'b1;
        inst_ready = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        start = req_count;
        repeat (20) @(negedge clk);
        #1;
        check("stall_req_count", req_count - start, 2);
        check("stall_valid", inst_valid, 1'b1);
        @(negedge clk);
        inst_ready = 1'b1;
        wait_req(addr, ok);
        if (ok) check("resume_addr", addr, 32'h8);

        // Redirect while the fetch at 0x8 is in WAIT
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_req(addr, ok);
        if (ok) check("redirect_req_addr", addr, 32'h40);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (inst_valid) begin
                n = 1;
                break;
            end
        end
        if (n == 0) timeout("redirect_inst");
        else check("redirect_inst_pc", inst_pc, 32'h40);

        // Redirect to a misaligned PC with the FIFO full and ready high
        @(negedge clk);
        inst_ready = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("full_valid", inst_valid, 1'b1);
        @(negedge clk);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h23;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("flush_valid_low", inst_valid, 1'b0);
        wait_req(addr, ok);
        if (ok) check("aligned_redirect_addr", addr, 32'h20);

        // Reset while a fetch is in WAIT
        wait_req(addr, ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_req(addr, ok);
        if (ok) check("post_reset_req_addr", addr, RESET_PC);
        repeat (15) @(negedge clk);

        // PC wraps modulo 2^32
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_req(addr, ok);
        if (ok) check("top_req_addr", addr, 32'hFFFF_FFFC);
        wait_req(addr, ok);
        if (ok) check("wrap_req_addr", addr, 32'h0);

        // Randomized traffic: ready, redirects, resets, memory timing
        rand_mem = 1'b1;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            inst_ready     = ($urandom_range(0, 9) < 7);
            n              = int'($urandom_range(0, 99));
            rst            = (n == 0);
            redirect_valid = (n >= 1 && n <= 3);
            if (redirect_valid) begin
                if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else                           redirect_pc = 32'($urandom_range(0, 511));
            end
        end
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        rand_mem       = 1'b0;
        inst_ready     = 1'b1;
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_ifetch_t
`default_nettype wire
